rep_pol_stamp: RTL and testbench
================================

// Module: rep_pol_stamp
// PURPOSE
//  Per-set recency tracker feeding the 4-way replacement comparator (rep_pol_comb).
//  Keeps one TS_WIDTH-bit access timestamp per way per set. A global counter stamps a way on every hit or fill.
//  A read port presents the four stamps of one set on line_0..line_3, so lowest stamp = LRU victim.
//  Renormalises on counter wrap so the relative order of ways survives.
// PARAMETERS
//  TS_WIDTH  32  timestamp width; line_n width (rep_pol_comb expects 32)
//  NUM_SETS  4   number of sets tracked; power of 2, >=2
//  SET_W     $clog2(NUM_SETS)  set index width (derived, do not override)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         async active-low reset
//  acc_valid  in   1         access request
//  acc_ready  out  1         tracker can accept access; low while renormalising
//  acc_set    in   SET_W     set of access
//  acc_way    in   2         way of access (0..3)
//  acc_inv    in   1         1 = invalidate way (stamp<=0), 0 = hit/fill (stamp<=ts)
//  rd_req     in   1         read request for stamps of rd_set
//  rd_set     in   SET_W     set to read
//  rd_valid   out  1         line_0..3 valid this cycle
//  line_0     out  TS_WIDTH  stamp of way 0 of last read set
//  line_1     out  TS_WIDTH  stamp of way 1
//  line_2     out  TS_WIDTH  stamp of way 2
//  line_3     out  TS_WIDTH  stamp of way 3
//  busy       out  1         renormalisation in progress (== !acc_ready)
// BEHAVIOUR
//  Reset (async, rst_n=0): all stamps 0, ts=1, FSM=IDLE, acc_ready=1, busy=0, rd_valid=0, line_0..3=0.
//  Accept: access takes effect on a clk edge with acc_valid & acc_ready. Stalled requests hold their inputs.
//  Hit/fill (acc_inv=0): stamp[set][way]<=ts; ts<=ts+1. If ts==all-ones, FSM->RENORM instead of increment.
//  Invalidate (acc_inv=1): stamp[set][way]<=0; ts unchanged; never triggers RENORM.
//  Never-used or invalidated ways hold 0, below any live stamp (ts>=1), so they are chosen first.
//  Read: rd_req sampled at edge N (when busy=0) -> rd_valid=1, line_n=stamps of rd_set at edge N+1.
//  - 1-cycle latency; rd_valid is a 1-cycle pulse per request; back-to-back reads every cycle.
//  - line_0..3 hold their last value while rd_valid=0.
//  - Same-edge read and write to the same set returns pre-write stamps; no bypass.
//  - rd_req while busy=1 is dropped: no rd_valid, line_n unchanged.
//  FSM:
//  - IDLE: acc_ready=1. Hit/fill with ts==all-ones -> RENORM, ptr=0.
//  - RENORM: acc_ready=0, busy=1. One set per cycle: all four stamps of set ptr <= stamp>>1; ptr++.
//  - RENORM exit: after set NUM_SETS-1 -> IDLE, ts<=2^(TS_WIDTH-1) (exceeds every shifted stamp).
//  - RENORM lasts exactly NUM_SETS cycles; acc_ready returns high on the following cycle.
//  - The wrapping access's own stamp (all-ones) is written before shifting, so it becomes 2^(W-1)-1 = newest.
//  - Shift may create equal stamps; ties are resolved downstream (rep_pol_comb picks the lowest way index).
//  Reset mid-RENORM: async clear to the full reset state; partial shifts are discarded.
//  Widths: ts and stamps are unsigned TS_WIDTH. Stamps never exceed ts-1 in IDLE.
// TESTING
//  Bench params: TS_WIDTH=4, NUM_SETS=2 unless noted.
//  T1 reset: rst_n=0 then release; read set 0 -> rd_valid next cycle, line_0..3=0,0,0,0, acc_ready=1.
//  T2 stamping, set0: hits way2, way0, way3, way1 -> read gives line_0..3 = 2,4,1,3 (ts starts at 1).
//  T3 invalidate: after T2, inv set0 way0 -> read gives 0,4,1,3; next hit way0 stamps 5 (ts not consumed).
//  T4 wrap: hits until ts=15, then hit set1 way1 -> busy=1 for 2 cycles, acc_ready=0.
//   - T4 check: set1 way1=7, other stamps halved, ts=8; next hit stamps 8.
//  T5 stall/drop: acc_valid held during RENORM -> applied on the first cycle acc_ready=1, exactly once.
//   - T5 check: rd_req during busy gives no rd_valid.
//  T6 read/write collision and mid-RENORM reset:
//   - Same-edge hit+read on set0 returns old stamps.
//   - rst_n=0 on the 2nd RENORM cycle -> all stamps 0, ts=1, busy=0 immediately.

Source files
------------

// File: rtl/rep_pol_stamp.sv
// Recency tracker for a 4-way set-associative replacement policy.
// Keeps one timestamp per way per set, stamped from a global counter on hit/fill.
// Invalidated or never-used ways hold 0, so the lowest stamp marks the LRU victim.
// When the counter wraps, every stamp is halved one set per cycle.
// The relative order of the ways survives this renormalisation.
module rep_pol_stamp #(
  parameter int TS_WIDTH = 32,
  parameter int NUM_SETS = 4,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_valid,
  output logic                acc_ready,
  input  logic [SET_W-1:0]    acc_set,
  input  logic [1:0]          acc_way,
  input  logic                acc_inv,
  input  logic                rd_req,
  input  logic [SET_W-1:0]    rd_set,
  output logic                rd_valid,
  output logic [TS_WIDTH-1:0] line_0,
  output logic [TS_WIDTH-1:0] line_1,
  output logic [TS_WIDTH-1:0] line_2,
  output logic [TS_WIDTH-1:0] line_3,
  output logic                busy
);

  typedef enum logic {ST_IDLE, ST_RENORM} state_t;

  localparam logic [TS_WIDTH-1:0] TS_MAX   = '1;
  // First counter value after renormalisation: above every halved stamp.
  localparam logic [TS_WIDTH-1:0] TS_HALF  = {1'b1, {(TS_WIDTH-1){1'b0}}};
  localparam logic [SET_W-1:0]    LAST_SET = SET_W'(NUM_SETS - 1);

  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [SET_W-1:0]    ptr_q, ptr_d;
  logic [TS_WIDTH-1:0] stamp_q [NUM_SETS][4];
  logic [TS_WIDTH-1:0] stamp_d [NUM_SETS][4];
  logic                rd_valid_q, rd_valid_d;
  logic [TS_WIDTH-1:0] line_q [4];
  logic [TS_WIDTH-1:0] line_d [4];

  logic idle;
  logic acc_fire;
  logic rd_fire;

  assign idle      = (state_q == ST_IDLE);
  assign acc_fire  = acc_valid & idle;
  assign rd_fire   = rd_req & idle;
  assign acc_ready = idle;
  assign busy      = ~idle;
  assign rd_valid  = rd_valid_q;
  assign line_0    = line_q[0];
  assign line_1    = line_q[1];
  assign line_2    = line_q[2];
  assign line_3    = line_q[3];

  // Next state for the counter, the renormalisation FSM and the set pointer.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_fire && !acc_inv) begin
          if (ts_q == TS_MAX) begin
            // The wrapping access keeps its all-ones stamp; halving makes it newest.
            state_d = ST_RENORM;
            ptr_d   = '0;
          end else begin
            ts_d = ts_q + 1'b1;
          end
        end
      end
      ST_RENORM: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_SET) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
          ts_d    = TS_HALF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stamp array update: write on accepted access, or halve the set under the pointer.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < 4; w++) begin
        stamp_d[s][w] = stamp_q[s][w];
        if (acc_fire && (acc_set == SET_W'(s)) && (acc_way == 2'(w))) begin
          stamp_d[s][w] = acc_inv ? '0 : ts_q;
        end else if ((state_q == ST_RENORM) && (ptr_q == SET_W'(s))) begin
          stamp_d[s][w] = stamp_q[s][w] >> 1;
        end
      end
    end
  end

  // Read port: capture pre-write stamps of rd_set; hold lines when no read fires.
  always_comb begin
    rd_valid_d = rd_fire;
    for (int w = 0; w < 4; w++) begin
      line_d[w] = rd_fire ? stamp_q[rd_set][w] : line_q[w];
    end
  end

  // All state registers; asynchronous clear returns the tracker to a fresh state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ts_q       <= TS_WIDTH'(1);
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      for (int w = 0; w < 4; w++) begin
        line_q[w] <= '0;
      end
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          stamp_q[s][w] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      for (int w = 0; w < 4; w++) begin
        line_q[w] <= line_d[w];
      end
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          stamp_q[s][w] <= stamp_d[s][w];
        end
      end
    end
  end

endmodule

// File: tb/tb_rep_pol_stamp.sv
// Self-checking bench for rep_pol_stamp with TS_WIDTH=4, NUM_SETS=2.
// Expected read results are queued when a read is issued and compared when rd_valid appears.
module tb_rep_pol_stamp;

  localparam int TS_W  = 4;
  localparam int NSETS = 2;
  localparam int TSMAX = (1 << TS_W) - 1;

  logic          clk;
  logic          rst_n;
  logic          acc_valid;
  logic          acc_ready;
  logic [0:0]    acc_set;
  logic [1:0]    acc_way;
  logic          acc_inv;
  logic          rd_req;
  logic [0:0]    rd_set;
  logic          rd_valid;
  logic [TS_W-1:0] line_0, line_1, line_2, line_3;
  logic          busy;

  rep_pol_stamp #(.TS_WIDTH(TS_W), .NUM_SETS(NSETS)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_set(acc_set),
    .acc_way(acc_way), .acc_inv(acc_inv),
    .rd_req(rd_req), .rd_set(rd_set), .rd_valid(rd_valid),
    .line_0(line_0), .line_1(line_1), .line_2(line_2), .line_3(line_3),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_stamp [NSETS][4];
  int          m_ts;
  bit          m_busy;
  int          m_ptr;
  logic [31:0] m_lines;
  logic [31:0] sb_q [$];
  logic [31:0] last_obs;
  bit          last_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_set(input int s);
    logic [31:0] p = '0;
    for (int w = 0; w < 4; w++) p |= 32'(m_stamp[s][w]) << (TS_W * w);
    return p;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < 4; w++) m_stamp[s][w] = 0;
    m_ts = 1; m_busy = 0; m_ptr = 0; m_lines = '0;
    sb_q.delete();
  endtask

  // One clock: predict, advance, update the model, then compare the observed cycle.
  task automatic step();
    bit exp_rd;
    bit accept;
    logic [31:0] obs;
    logic [31:0] exp_l;
    exp_rd = rd_req && !m_busy;
    accept = acc_valid && !m_busy;
    if (exp_rd) sb_q.push_back(pack_set(int'(rd_set)));
    @(posedge clk);
    #1;
    if (!m_busy) begin
      if (accept) begin
        if (acc_inv) m_stamp[acc_set][acc_way] = 0;
        else begin
          m_stamp[acc_set][acc_way] = m_ts;
          if (m_ts == TSMAX) begin m_busy = 1; m_ptr = 0; end
          else m_ts++;
        end
      end
    end else begin
      for (int w = 0; w < 4; w++) m_stamp[m_ptr][w] = m_stamp[m_ptr][w] >> 1;
      if (m_ptr == NSETS - 1) begin m_busy = 0; m_ts = 1 << (TS_W - 1); m_ptr = 0; end
      else m_ptr++;
    end
    last_accept = accept;
    obs = {16'h0, line_3, line_2, line_1, line_0};
    chk("rd_valid", 32'(rd_valid), 32'(exp_rd));
    if (exp_rd) begin
      exp_l = sb_q.pop_front();
      chk("rd_lines", obs, exp_l);
      m_lines  = exp_l;
      last_obs = obs;
    end else begin
      chk("line_hold", obs, m_lines);
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("acc_ready", 32'(acc_ready), 32'(!m_busy));
  endtask

  task automatic do_acc(input int s, input int w, input bit inv, output int waits);
    acc_valid = 1'b1; acc_set = 1'(s); acc_way = 2'(w); acc_inv = inv;
    waits = 0;
    do begin
      step();
      if (!last_accept) waits++;
    end while (!last_accept && waits < 20);
    if (!last_accept) chk("acc_timeout", 32'd0, 32'd1);
    acc_valid = 1'b0; acc_inv = 1'b0;
  endtask

  task automatic do_read(input int s);
    rd_req = 1'b1; rd_set = 1'(s);
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    rst_n = 1'b0; acc_valid = 1'b0; acc_set = '0; acc_way = '0; acc_inv = 1'b0;
    rd_req = 1'b0; rd_set = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // T1: reset state
    chk("rst_ready", 32'(acc_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_lines", {16'h0, line_3, line_2, line_1, line_0}, 32'h0);
    rst_n = 1'b1;
    do_read(0);
    chk("t1_set0", last_obs, 32'h0000);

    // T2: stamping order on set 0
    do_acc(0, 2, 0, wt); do_acc(0, 0, 0, wt); do_acc(0, 3, 0, wt); do_acc(0, 1, 0, wt);
    do_read(0);
    chk("t2_set0", last_obs, 32'h3142);

    // T3: invalidate does not consume a timestamp
    do_acc(0, 0, 1, wt);
    do_read(0);
    chk("t3_inv", last_obs, 32'h3140);
    do_acc(0, 0, 0, wt);
    do_read(0);
    chk("t3_restamp", last_obs, 32'h3145);

    // T4: fill up to the wrap (ts 6..14), then wrap on set1 way1
    for (int w = 0; w < 4; w++) do_acc(1, w, 0, wt);
    for (int w = 0; w < 4; w++) do_acc(0, w, 0, wt);
    do_acc(0, 0, 0, wt);
    do_acc(1, 1, 0, wt);
    chk("t4_busy", 32'(busy), 32'd1);
    // T5: access and read held through renormalisation
    rd_req = 1'b1; rd_set = 1'b1;
    do_acc(0, 1, 0, wt);
    rd_req = 1'b0;
    chk("t5_wait", 32'(wt), 32'(NSETS));
    chk("t4_set1", last_obs, 32'h4473);
    do_read(0);
    chk("t5_set0", last_obs, 32'h6687);

    // T6: same-edge hit and read return pre-write stamps
    acc_valid = 1'b1; acc_set = 1'b0; acc_way = 2'd2; acc_inv = 1'b0;
    rd_req = 1'b1; rd_set = 1'b0;
    step();
    acc_valid = 1'b0; rd_req = 1'b0;
    chk("t6_accept", 32'(last_accept), 32'd1);
    chk("t6_collide", last_obs, 32'h6687);
    do_read(0);
    chk("t6_after", last_obs, 32'h6987);

    // T6: wrap again and reset on the second renormalisation cycle
    for (int w = 0; w < 4; w++) do_acc(1, w, 0, wt);
    do_acc(1, 0, 0, wt);
    do_acc(0, 0, 0, wt);
    step();
    chk("t6_still_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(acc_ready), 32'd1);
    chk("t6_rst_rdv", 32'(rd_valid), 32'd0);
    chk("t6_rst_lines", {16'h0, line_3, line_2, line_1, line_0}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_read(0);
    chk("t6_set0_clr", last_obs, 32'h0000);
    do_read(1);
    chk("t6_set1_clr", last_obs, 32'h0000);
    do_acc(1, 3, 0, wt);
    do_read(1);
    chk("t6_ts_restart", last_obs, 32'h1000);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
